// File: rtl/multi_button_counter.sv
// multi_button_counter
//   N-channel push-button front end. Each channel runs through a 2-FF
//   synchroniser, a tick-sampled debouncer, an edge detector and an event
//   counter. One tick generator shared by all channels sets the debounce
//   sampling rate.
//
// Ports
//   CLK_I     system clock
//   RST_I     synchronous, active-high reset (priority over all inputs)
//   BUT_I     [N_CH]        raw asynchronous button inputs
//   CLR_I     [N_CH]        per-channel clear of count and overflow flag
//   LEVEL_O   [N_CH]        debounced button level
//   EDGE_O    [N_CH]        one-cycle pulse on a counted edge of LEVEL_O
//   CNTVAL_O  [N_CH*CNT_W]  packed counts, channel k at [k*CNT_W +: CNT_W]
//   OV_O      [N_CH]        sticky wrap/saturation flag
//
// All outputs come straight from flops. There is no combinational path
// from any input to any output.
module multi_button_counter #(
  parameter int   N_CH      = 4,
  parameter int   CNT_W     = 8,
  parameter int   TICK_DIV  = 250000,
  parameter int   STABLE_N  = 4,
  parameter int   EDGE_MODE = 0,
  parameter int   SAT_MODE  = 0,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [N_CH-1:0]         BUT_I,
  input  logic [N_CH-1:0]         CLR_I,
  output logic [N_CH-1:0]         LEVEL_O,
  output logic [N_CH-1:0]         EDGE_O,
  output logic [N_CH*CNT_W-1:0]   CNTVAL_O,
  output logic [N_CH-1:0]         OV_O
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  // STABLE_N is at most 15, so the run counter never needs more than 4 bits.
  localparam logic [3:0]        STAB_LAST = 4'(STABLE_N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick;

  logic [N_CH-1:0]   s1_q, s1_d;
  logic [N_CH-1:0]   s2_q, s2_d;
  logic [N_CH-1:0]   level_q, level_d;
  logic [N_CH-1:0]   edge_q, edge_d;
  logic [N_CH-1:0]   ov_q, ov_d;
  logic [3:0]        stab_q [N_CH];
  logic [3:0]        stab_d [N_CH];
  logic [CNT_W-1:0]  cnt_q  [N_CH];
  logic [CNT_W-1:0]  cnt_d  [N_CH];

  always_comb begin
    tick   = (tick_q == TICK_LAST);
    tick_d = tick ? '0 : tick_q + 1'b1;
  end

  always_comb begin
    s1_d    = BUT_I;
    s2_d    = s1_q;
    level_d = level_q;
    edge_d  = '0;
    ov_d    = ov_q;
    for (int k = 0; k < N_CH; k++) begin
      stab_d[k] = stab_q[k];
      cnt_d[k]  = cnt_q[k];

      // Debounce: the run counter tracks how many consecutive tick samples
      // disagreed with the accepted level; any agreeing sample restarts it.
      if (tick) begin
        if (s2_q[k] == level_q[k]) begin
          stab_d[k] = '0;
        end else if (stab_q[k] == STAB_LAST) begin
          level_d[k] = s2_q[k];
          stab_d[k]  = '0;
        end else begin
          stab_d[k] = stab_q[k] + 4'd1;
        end
      end

      // Edge is judged on the level transition being registered this cycle,
      // so EDGE_O rises together with the new LEVEL_O value.
      if (EDGE_MODE == 0) begin
        edge_d[k] = level_q[k] & ~level_d[k];
      end else if (EDGE_MODE == 1) begin
        edge_d[k] = ~level_q[k] & level_d[k];
      end else begin
        edge_d[k] = level_q[k] ^ level_d[k];
      end

      // Clear beats a coincident counted edge; the edge pulse still goes out.
      if (CLR_I[k]) begin
        cnt_d[k] = '0;
        ov_d[k]  = 1'b0;
      end else if (edge_d[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ov_d[k] = 1'b1;
          if (SAT_MODE == 0) begin
            cnt_d[k] = '0;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tick_q  <= '0;
      s1_q    <= {N_CH{IDLE_LVL}};
      s2_q    <= {N_CH{IDLE_LVL}};
      level_q <= {N_CH{IDLE_LVL}};
      edge_q  <= '0;
      ov_q    <= '0;
      for (int k = 0; k < N_CH; k++) begin
        stab_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      tick_q  <= tick_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      edge_q  <= edge_d;
      ov_q    <= ov_d;
      for (int k = 0; k < N_CH; k++) begin
        stab_q[k] <= stab_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  always_comb begin
    CNTVAL_O = '0;
    for (int k = 0; k < N_CH; k++) begin
      CNTVAL_O[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  assign LEVEL_O = level_q;
  assign EDGE_O  = edge_q;
  assign OV_O    = ov_q;

endmodule
